// File: rtl/timer_pkg.sv
// Shared types and helpers for the mm:ss countdown timer.
// BCD packing is {m10, m1, s10, s1}.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } timer_state_t;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  function automatic logic bcd_time_valid(
    logic [15:0] v
  );
    return (v[15:12] <= DIGIT_MAX) &&
           (v[11:8]  <= DIGIT_MAX) &&
           (v[7:4]   <= SEC_TENS_MAX) &&
           (v[3:0]   <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the down-counting borrow chain.
// A digit at zero wraps to MAX and passes the borrow on.
module bcd_digit_dec #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] next,
  output logic       borrow_out
);

  always_comb begin
    next       = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        next       = MAX;
        borrow_out = 1'b1;
      end else begin
        next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown timer: prescaled one-second ticks,
// run/pause control, expiry flag and load validation.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] set_value,
  output logic [15:0] digits,
  output logic        running,
  output logic        expired,
  output logic        done,
  output logic        load_err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  timer_state_t  state;
  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   dec_val;
  logic [4:0]    borrow;
  logic          at_end;

  assign tick      = (state == RUN) && (presc == LAST);
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < 4; i++) begin : g_dec
    localparam logic [3:0] DMAX =
      (i == 1) ? SEC_TENS_MAX : DIGIT_MAX;
    bcd_digit_dec #(.MAX(DMAX)) u_dec (
      .digit      (digits[4*i +: 4]),
      .borrow_in  (borrow[i]),
      .next       (dec_val[4*i +: 4]),
      .borrow_out (borrow[i+1])
    );
  end

  // A borrow out of m10 cannot occur from a nonzero value,
  // but treat it as expiry rather than wrapping to 99:59.
  assign at_end = (dec_val == 16'h0000) || borrow[4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      digits   <= 16'h0000;
      running  <= 1'b0;
      expired  <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      unique case (state)
        RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            digits <= at_end ? 16'h0000 : dec_val;
          end
          if (tick && at_end) begin
            state   <= EXPIRED;
            running <= 1'b0;
            expired <= 1'b1;
            done    <= 1'b1;
          end else if (stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        IDLE, PAUSE, EXPIRED: begin
          if (load) begin
            if (bcd_time_valid(set_value)) begin
              digits  <= set_value;
              state   <= IDLE;
              presc   <= '0;
              expired <= 1'b0;
            end else begin
              load_err <= 1'b1;
            end
          end else if (start && (state != EXPIRED) &&
                       (digits != 16'h0000)) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          expired <= 1'b0;
        end
      endcase
    end
  end

endmodule
